// File: rtl/fc_input_feeder_pkg.sv
// fc_input_feeder_pkg: shared types and default sizes for the CNN-to-FC input feeder
// Contents: default geometry, watchdog limit, timeout class code, word type and FSM state type.
// Optional feature macro: FC_FEEDER_TIMEOUT_EN (consumes TIMEOUT_CYCLES).
package fc_input_feeder_pkg;
  localparam int DEF_INPUT_SIZE = 120;
  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_CNT_WIDTH = 7;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam logic [3:0] CLASS_TIMEOUT = 4'hF;
  typedef logic [DEF_WORD_SIZE-1:0] fc_word_t;
  typedef enum logic [2:0] {FILL, ARM, WAIT, CAPT, RESULT} fc_feed_state_t;
endpackage

// File: rtl/fc_input_feeder_if.sv
// fc_input_feeder_if: feature stream, FC start/done handshake and result port bundle
// master: the feeder (drives in_ready, FC_inputs, CNN_ready, result_*, frame_err, busy)
// slave:  the environment (drives in_valid/in_data/in_last, FC_output, done, result_ready)
interface fc_input_feeder_if
  import fc_input_feeder_pkg::*;
#(
  parameter int FC_INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE
);
  logic in_valid;
  logic [WORD_SIZE-1:0] in_data;
  logic in_last;
  logic in_ready;
  logic [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0] FC_inputs;
  logic CNN_ready;
  logic [3:0] FC_output;
  logic done;
  logic result_valid;
  logic [3:0] result_class;
  logic result_ready;
  logic frame_err;
  logic busy;
  modport master (
    input in_valid, in_data, in_last, FC_output, done, result_ready,
    output in_ready, FC_inputs, CNN_ready, result_valid, result_class, frame_err, busy
  );
  modport slave (
    output in_valid, in_data, in_last, FC_output, done, result_ready,
    input in_ready, FC_inputs, CNN_ready, result_valid, result_class, frame_err, busy
  );
endinterface

// File: rtl/fc_input_feeder_frame_buffer.sv
// fc_frame_buffer: feature-vector register array with single write port and full packed read-out
// Ports: clk, rst_n (async active-low), clr_i (sync clear-all), we_i/waddr_i/wdata_i (write),
//        rdata_o (whole array, entry 0 leftmost).
module fc_frame_buffer
  import fc_input_feeder_pkg::*;
#(
  parameter int DEPTH = DEF_INPUT_SIZE,
  parameter int WIDTH = DEF_WORD_SIZE,
  parameter int AW = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [0:DEPTH-1][WIDTH-1:0] rdata_o
);
  logic [0:DEPTH-1][WIDTH-1:0] mem_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '0;
    else if (clr_i) mem_q <= '0;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q;
endmodule

// File: rtl/fc_input_feeder.sv
// fc_input_feeder: gathers a CNN feature frame, starts the FC block and returns its class index
// Ports: clk, rst (async active-low), bus (fc_input_feeder_if.master: feature stream in,
//        FC_inputs/CNN_ready/FC_output/done to the FC block, result valid/ready out, frame_err, busy).
// Optional feature macro: FC_FEEDER_TIMEOUT_EN adds a WAIT watchdog that forces class 4'hF.
module fc_input_feeder
  import fc_input_feeder_pkg::*;
#(
  parameter int FC_INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic clk,
  input logic rst,
  fc_input_feeder_if.master bus
);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FC_INPUT_SIZE - 1);
  fc_feed_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [3:0] class_q, class_d;
  logic in_ready_q, done_q, frame_err_q, frame_err_d;
  logic accept, at_last, done_rise, clr, to_hit, to_q;
  assign accept = bus.in_valid & in_ready_q;
  assign at_last = count_q == LAST_IDX;
  // done_q tracks done every cycle, so a level already high at ARM never looks like an edge in WAIT
  assign done_rise = bus.done & ~done_q;
`ifdef FC_FEEDER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;
  logic timeout_q;
  logic [4:0] status;
  assign to_hit = (state_q == WAIT) && !done_rise && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
  assign status = {timeout_q, frame_err_q, state_q};
  // to_q marks that the pending capture comes from the watchdog rather than the FC block
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= (state_q == WAIT) ? wd_q + 1'b1 : '0;
      to_q <= to_hit | (to_q & (state_q != RESULT));
      timeout_q <= timeout_q | to_hit;
    end
`else
  assign to_hit = 1'b0;
  assign to_q = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    class_d = class_q;
    frame_err_d = frame_err_q;
    clr = 1'b0;
    case (state_q)
      FILL: if (accept) begin
        count_d = at_last ? count_q : count_q + 1'b1;
        if (bus.in_last | at_last) begin
          state_d = ARM;
          frame_err_d = frame_err_q | (bus.in_last ^ at_last);
        end
      end
      ARM: state_d = WAIT;
      WAIT: state_d = (done_rise | to_hit) ? CAPT : WAIT;
      CAPT: begin
        class_d = to_q ? CLASS_TIMEOUT : bus.FC_output;
        state_d = RESULT;
      end
      RESULT: if (bus.result_ready) begin
        clr = 1'b1;
        count_d = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FILL;
      count_q <= '0;
      class_q <= '0;
      in_ready_q <= 1'b0;
      done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      class_q <= class_d;
      in_ready_q <= state_d == FILL;
      done_q <= bus.done;
      frame_err_q <= frame_err_d;
    end
  // Short frames need no explicit zero-fill: the buffer is cleared on every result hand-off
  fc_frame_buffer #(.DEPTH(FC_INPUT_SIZE), .WIDTH(WORD_SIZE), .AW(CNT_WIDTH)) u_buf (
    .clk(clk),
    .rst_n(rst),
    .clr_i(clr),
    .we_i(accept),
    .waddr_i(count_q),
    .wdata_i(bus.in_data),
    .rdata_o(bus.FC_inputs)
  );
  assign bus.in_ready = in_ready_q;
  assign bus.CNN_ready = state_q == ARM;
  assign bus.busy = state_q != FILL;
  assign bus.result_valid = state_q == RESULT;
  assign bus.result_class = class_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_fc_input_feeder.sv
// tb_fc_input_feeder: randomized self-checking bench for fc_input_feeder against a frame-level model
module tb_fc_input_feeder;
  localparam int N = 120;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_buf [N];
  logic exp_ferr = 1'b0;
  logic [3:0] cls;
  logic [W-1:0] d0;

  fc_input_feeder_if #(.FC_INPUT_SIZE(N), .WORD_SIZE(W)) bus ();
  fc_input_feeder #(.FC_INPUT_SIZE(N), .WORD_SIZE(W), .CNT_WIDTH(7)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) exp_buf[i] = '0;
  endtask

  function automatic int vec_diffs();
    int d = 0;
    for (int i = 0; i < N; i++) if (bus.FC_inputs[i] !== exp_buf[i]) d++;
    return d;
  endfunction

  task automatic push(input logic [W-1:0] d, input logic l);
    int k = 0;
    while ($urandom_range(3) == 0 && k < 3) begin tick(); k++; end
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = l;
    k = 0;
    while (!bus.in_ready && k < 64) begin tick(); k++; end
    checks++;
    if (k == 64) begin errors++; $display("FAIL push_ready in_ready=%b required 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  // Frame model: words land at their arrival index, the rest stay zero; frame_err is sticky
  // unless the last accepted word is word N-1 carrying in_last.
  task automatic send_frame(input int first, input int n, input bit seq, input bit with_last);
    logic [W-1:0] d;
    if (first == 0) model_clear();
    for (int i = first; i < n; i++) begin
      d = seq ? W'(i + 1) : W'($urandom);
      exp_buf[i] = d;
      push(d, with_last && (i == n - 1));
    end
    exp_ferr = exp_ferr | !(n == N && with_last);
  endtask

  task automatic run_fc(input int delay, input logic [3:0] c);
    repeat (delay) tick();
    bus.FC_output = c;
    bus.done = 1'b1;
    tick();
    tick();
  endtask

  task automatic consume(input int hold);
    bus.done = 1'b0;
    repeat (hold) tick();
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.in_ready, bus.CNN_ready, bus.result_valid, bus.busy, bus.frame_err} !== 5'b0 ||
        bus.result_class !== 4'd0 || bus.FC_inputs !== '0)
      begin errors++; $display("FAIL reset_outputs rdy=%b cnn=%b rv=%b busy=%b ferr=%b cls=%h required all 0",
        bus.in_ready, bus.CNN_ready, bus.result_valid, bus.busy, bus.frame_err, bus.result_class); end
    rst = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_early in_ready=%b required 0", bus.in_ready); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reset_release in_ready=%b busy=%b required 1 0", bus.in_ready, bus.busy); end
    model_clear();
    exp_ferr = 1'b0;
  endtask

  task automatic test_full_frame();
    send_frame(0, N, 1'b1, 1'b1);
    checks++;
    if (bus.CNN_ready !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL full_arm cnn=%b busy=%b rdy=%b required 1 1 0", bus.CNN_ready, bus.busy, bus.in_ready); end
    checks++;
    if (bus.FC_inputs[0] !== 16'd1 || bus.FC_inputs[N-1] !== 16'd120)
      begin errors++; $display("FAIL full_ends [0]=%0d [119]=%0d required 1 120", bus.FC_inputs[0], bus.FC_inputs[N-1]); end
    checks++;
    if (vec_diffs() != 0) begin errors++; $display("FAIL full_vector diffs=%0d required 0", vec_diffs()); end
    checks++;
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL full_frame_err got=%b required 0", bus.frame_err); end
  endtask

  task automatic test_fc_done();
    tick();
    checks++;
    if (bus.CNN_ready !== 1'b0) begin errors++; $display("FAIL cnn_pulse_width cnn=%b required 0", bus.CNN_ready); end
    repeat (5) tick();
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL wait_idle rv=%b busy=%b required 0 1", bus.result_valid, bus.busy); end
    run_fc(1, 4'd3);
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_class !== 4'd3)
      begin errors++; $display("FAIL done_capture rv=%b cls=%0d required 1 3", bus.result_valid, bus.result_class); end
    checks++;
    if (vec_diffs() != 0) begin errors++; $display("FAIL vector_stable diffs=%0d required 0", vec_diffs()); end
    consume(0);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || vec_diffs() != 0)
      begin errors++; $display("FAIL consume rv=%b busy=%b rdy=%b diffs=%0d required 0 0 1 0",
        bus.result_valid, bus.busy, bus.in_ready, vec_diffs()); end
  endtask

  task automatic test_short_frame();
    send_frame(0, 50, 1'b0, 1'b1);
    checks++;
    if (bus.CNN_ready !== 1'b1 || bus.frame_err !== 1'b1)
      begin errors++; $display("FAIL short_arm cnn=%b ferr=%b required 1 1", bus.CNN_ready, bus.frame_err); end
    checks++;
    if (vec_diffs() != 0 || bus.FC_inputs[50] !== '0 || bus.FC_inputs[N-1] !== '0)
      begin errors++; $display("FAIL short_zero_fill diffs=%0d [50]=%h [119]=%h required 0 0 0",
        vec_diffs(), bus.FC_inputs[50], bus.FC_inputs[N-1]); end
    cls = 4'($urandom_range(10, 15));
    run_fc($urandom_range(1, 10), cls);
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_class !== cls)
      begin errors++; $display("FAIL short_class rv=%b cls=%0d required 1 %0d", bus.result_valid, bus.result_class, cls); end
  endtask

  task automatic test_hold_result();
    int bad = 0;
    d0 = W'($urandom);
    bus.in_valid = 1'b1;
    bus.in_data = d0;
    repeat (20) begin
      tick();
      if (bus.in_ready !== 1'b0 || bus.result_valid !== 1'b1 || bus.result_class !== cls) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_result bad_cycles=%0d required 0", bad); end
    bus.done = 1'b0;
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    model_clear();
    checks++;
    if (bus.result_valid !== 1'b0 || bus.in_ready !== 1'b1 || vec_diffs() != 0)
      begin errors++; $display("FAIL hold_release rv=%b rdy=%b diffs=%0d required 0 1 0", bus.result_valid, bus.in_ready, vec_diffs()); end
    tick();
    bus.in_valid = 1'b0;
    exp_buf[0] = d0;
    checks++;
    if (bus.FC_inputs[0] !== d0 || vec_diffs() != 0)
      begin errors++; $display("FAIL first_word [0]=%h required %h diffs=%0d", bus.FC_inputs[0], d0, vec_diffs()); end
  endtask

  task automatic test_done_held();
    int bad = 0;
    bus.done = 1'b1;
    send_frame(1, 80, 1'b0, 1'b1);
    checks++;
    if (bus.CNN_ready !== 1'b1 || vec_diffs() != 0 || bus.frame_err !== exp_ferr)
      begin errors++; $display("FAIL held_arm cnn=%b diffs=%0d ferr=%b required 1 0 %b", bus.CNN_ready, vec_diffs(), bus.frame_err, exp_ferr); end
    repeat (10) begin
      tick();
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL held_done_ignored bad_cycles=%0d required 0", bad); end
    bus.done = 1'b0;
    tick();
    tick();
    cls = 4'($urandom);
    run_fc(0, cls);
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_class !== cls)
      begin errors++; $display("FAIL held_rearm rv=%b cls=%0d required 1 %0d", bus.result_valid, bus.result_class, cls); end
    consume(0);
  endtask

  task automatic test_random();
    int n;
    bit wl;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, N);
      wl = (n < N) ? 1'b1 : 1'($urandom_range(1));
      send_frame(0, n, 1'b0, wl);
      checks++;
      if (bus.CNN_ready !== 1'b1 || vec_diffs() != 0 || bus.frame_err !== exp_ferr)
        begin errors++; $display("FAIL rand_arm it=%0d n=%0d cnn=%b diffs=%0d ferr=%b required 1 0 %b",
          it, n, bus.CNN_ready, vec_diffs(), bus.frame_err, exp_ferr); end
      cls = 4'($urandom);
      run_fc($urandom_range(1, 20), cls);
      checks++;
      if (bus.result_valid !== 1'b1 || bus.result_class !== cls)
        begin errors++; $display("FAIL rand_class it=%0d rv=%b cls=%0d required 1 %0d", it, bus.result_valid, bus.result_class, cls); end
      consume($urandom_range(0, 5));
      checks++;
      if (bus.in_ready !== 1'b1 || bus.result_valid !== 1'b0 || vec_diffs() != 0)
        begin errors++; $display("FAIL rand_consume it=%0d rdy=%b rv=%b diffs=%0d required 1 0 0", it, bus.in_ready, bus.result_valid, vec_diffs()); end
    end
  endtask

  task automatic test_reset_in_wait();
    int bad = 0;
    send_frame(0, $urandom_range(1, N), 1'b0, 1'b1);
    repeat (30) begin
      tick();
      if (bus.result_valid !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wait_forever bad_cycles=%0d required 0", bad); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.CNN_ready, bus.result_valid, bus.busy, bus.frame_err} !== 5'b0 ||
        bus.result_class !== 4'd0 || bus.FC_inputs !== '0)
      begin errors++; $display("FAIL async_reset rdy=%b cnn=%b rv=%b busy=%b ferr=%b cls=%h required all 0",
        bus.in_ready, bus.CNN_ready, bus.result_valid, bus.busy, bus.frame_err, bus.result_class); end
    #1 rst = 1'b1;
    model_clear();
    exp_ferr = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL wait_reset_release rdy=%b busy=%b required 1 0", bus.in_ready, bus.busy); end
  endtask

`ifdef FC_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    send_frame(0, N, 1'b1, 1'b1);
    bus.FC_output = 4'd5;
    repeat (4097) tick();
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL timeout_early rv=%b required 0", bus.result_valid); end
    tick();
    checks++;
    if (bus.result_valid !== 1'b1 || bus.result_class !== 4'hF)
      begin errors++; $display("FAIL timeout_class rv=%b cls=%h required 1 f", bus.result_valid, bus.result_class); end
    consume(0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.FC_output = 4'd0;
    bus.done = 1'b0;
    bus.result_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_fc_done();
    test_short_frame();
    test_hold_result();
    test_done_held();
    test_random();
    test_reset_in_wait();
`ifdef FC_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
